// File: rtl/button_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
//   Shared constants for the button/switch front-end of the logic processor.
//   Holds the default debounce length, the electrical "released" level of a
//   raw active-low button, the channel index of each push button and the bit
//   offsets of the fields packed into the slide-switch bus.
// ---------------------------------------------------------------------------
package button_pkg;

  // 5 ms at 50 MHz
  localparam int DEBOUNCE_DEFAULT = 250000;

  // Raw buttons are active-low, so an idle pin reads 1
  localparam logic BTN_RELEASED = 1'b1;

  // Push-button channel indices
  localparam int BTN_EXECUTE = 0;
  localparam int BTN_LOADA   = 1;
  localparam int BTN_LOADB   = 2;

  // Slide-switch field offsets: Din[3:0], F[6:4], R[8:7]
  localparam int DIN_LSB = 0;
  localparam int F_LSB   = 4;
  localparam int R_LSB   = 7;

endpackage

// File: rtl/button_conditioner_if.sv
// ---------------------------------------------------------------------------
// button_conditioner_if
//   Bundles the board-side raw inputs and the conditioned outputs of the
//   button conditioner.
//   Signals:
//     btn_n       raw active-low push buttons (asynchronous)
//     sw_raw      raw slide switches (asynchronous)
//     btn_level   debounced button state, 1 = pressed
//     btn_press   one-cycle pulse on an accepted press
//     btn_release one-cycle pulse on an accepted release
//     sw_sync     switches after a 2-FF synchroniser
//   Modports:
//     master  drives the raw pins, observes the conditioned outputs
//     slave   the conditioner itself
// ---------------------------------------------------------------------------
interface button_conditioner_if #(
  parameter int NUM_BTN = 3,
  parameter int SW_W    = 9
);

  logic [NUM_BTN-1:0] btn_n;
  logic [SW_W-1:0]    sw_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [SW_W-1:0]    sw_sync;

  modport master (
    output btn_n,
    output sw_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  sw_sync
  );

  modport slave (
    input  btn_n,
    input  sw_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output sw_sync
  );

endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
//   Conditions one raw active-low push button: 2-FF synchroniser, counter
//   based debounce against a stable state, registered active-high level and
//   one-cycle press/release pulses.
//   Ports:
//     Clk        system clock
//     Reset      asynchronous active-low reset
//     btn_n      raw button pin, active-low, asynchronous to Clk
//     level_o    debounced level, 1 = pressed
//     press_o    one-cycle pulse when a press is accepted
//     release_o  one-cycle pulse when a release is accepted
// ---------------------------------------------------------------------------
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_n,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             stb_q, stb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1_q      <= BTN_RELEASED;
      s2_q      <= BTN_RELEASED;
      stb_q     <= BTN_RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stb_q     <= stb_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // A change is accepted only after DEBOUNCE_CYCLES consecutive samples that
  // differ from the stable state; any sample matching it restarts the count,
  // so the counter never wraps.
  always_comb begin
    s1_d      = btn_n;
    s2_d      = s1_q;
    stb_d     = stb_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s2_q != stb_q) begin
      if (cnt_q == CNT_LAST) begin
        stb_d     = s2_q;
        press_d   = (s2_q != BTN_RELEASED);
        release_d = (s2_q == BTN_RELEASED);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Level follows the new stable state so it rises with the press pulse
    level_d = ~stb_d;
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Front-end for the logic processor. Debounces the active-low Execute,
//   LoadA and LoadB buttons into clean levels and single press/release
//   pulses, and synchronises the Din/F/R slide switches into the Clk domain.
//   Ports:
//     Clk    system clock (50 MHz)
//     Reset  asynchronous active-low reset
//     bus    slave side of button_conditioner_if (raw pins in, conditioned
//            levels/pulses and synchronised switches out)
//   DEBOUNCE_CYCLES must be at least 2.
// ---------------------------------------------------------------------------
module button_conditioner
  import button_pkg::*;
#(
  parameter int NUM_BTN         = 3,
  parameter int SW_W            = 9,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Reset,
  button_conditioner_if.slave  bus
);

  logic [NUM_BTN-1:0] btn_level_w;
  logic [NUM_BTN-1:0] btn_press_w;
  logic [NUM_BTN-1:0] btn_release_w;

  logic [SW_W-1:0] sw_s1_q, sw_s1_d;
  logic [SW_W-1:0] sw_s2_q, sw_s2_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_channel (
      .Clk       (Clk),
      .Reset     (Reset),
      .btn_n     (bus.btn_n[i]),
      .level_o   (btn_level_w[i]),
      .press_o   (btn_press_w[i]),
      .release_o (btn_release_w[i])
    );
  end

  // Switches are quasi-static, so a plain 2-FF synchroniser is enough
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
    end
  end

  always_comb begin
    sw_s1_d = bus.sw_raw;
    sw_s2_d = sw_s1_q;
  end

  assign bus.btn_level   = btn_level_w;
  assign bus.btn_press   = btn_press_w;
  assign bus.btn_release = btn_release_w;
  assign bus.sw_sync     = sw_s2_q;

endmodule
